lda_control: RTL and testbench
==============================

// Module: lda_control
// PURPOSE
//  Sequencing FSM for the line-drawing (Bresenham) datapath. Accepts a start
//  request and pulses the datapath load strobes in the required order. Steps
//  x/error/y each pixel and issues one plot request per pixel to the VGA
//  writer, with backpressure. A pixel watchdog aborts runaway lines.
// PARAMETERS
//  MAX_PIXELS  512  plots allowed per line before forced abort (>=1)
// PORTS
//  i_clk         in   1   system clock, all state on rising edge
//  i_reset_n     in   1   asynchronous, active-low reset
//  i_start       in   1   start request; sampled only in IDLE
//  o_busy        out  1   1 in every state except IDLE
//  o_done        out  1   one-cycle pulse: line finished (normal or abort)
//  o_abort       out  1   one-cycle pulse with o_done when watchdog fired
//  o_ld_constants out 1   datapath: latch steep,dx,dy,error,x/ystep,x,y
//  o_ld_x        out  1   datapath: x <= x + xstep
//  o_ld_y        out  1   datapath: y <= y + ystep
//  o_ld_error    out  1   datapath: error <= error op (per o_err_sel)
//  o_err_sel     out  1   0: error - dy, 1: error + dx
//  i_x_eq_x1     in   1   datapath: current x equals end x
//  i_error_neg   in   1   datapath: registered error < 0
//  o_plot        out  1   plot request for current (x,y)
//  i_plot_ready  in   1   VGA writer accepts plot when o_plot && ready
// BEHAVIOUR
//  Reset (async, i_reset_n=0): state=IDLE, pixel count=0; all outputs 0.
//  Strobes are combinational from state (Mealy in PLOT/CHECK) and therefore
//  0 whenever the state is IDLE.
//  States / transitions:
//   IDLE : i_start=1 -> LOAD. o_busy=0.
//   LOAD : 1 cycle, o_ld_constants=1, count<=0 -> PLOT.
//   PLOT : o_plot=1 until accept (o_plot&&i_plot_ready).
//          On accept, count<=count+1, then:
//          i_x_eq_x1=1 -> DONE. Else count+1==MAX_PIXELS -> ABORT.
//          Else -> STEP. No accept: remain, no other strobes.
//   STEP : 1 cycle, o_ld_x=1, o_ld_error=1, o_err_sel=0 -> CHECK.
//   CHECK: 1 cycle. If i_error_neg: o_ld_y=1, o_ld_error=1, o_err_sel=1.
//          -> PLOT either way.
//   DONE : 1 cycle, o_done=1 -> IDLE.
//   ABORT: 1 cycle, o_done=1, o_abort=1 -> IDLE.
//  i_start outside IDLE is ignored (not queued). i_start held high in DONE
//  or ABORT is seen on the next IDLE cycle, so back-to-back lines work.
//  x0==x1: exactly one plot, then DONE. x_eq_x1 takes priority over the
//  watchdog on the same accept.
//  Count width $clog2(MAX_PIXELS+1), no wrap (bounded by ABORT).
//  Per-pixel cost with ready=1: 3 cycles (PLOT, STEP, CHECK).
//  Reset mid-line: immediate IDLE, no o_done.
// CONFIGURATION
//  LDA_PIXEL_COUNT_EN defined: adds port o_pixel_count (out, count width),
//   which holds accepted plots of the current or last line. Cleared in LOAD
//   and by reset; holds its value in IDLE.
//  Undefined: no port. Internal count is used only for the watchdog.
// TESTING
//  Horizontal (0,0)-(4,0), ready=1, error_neg=0 -> 5 plots.
//   o_done 15 cycles after the i_start cycle, o_abort=0.
//  Single point x0=x1=7 -> 1 plot, no o_ld_x. o_done 3 cycles after start.
//  Diagonal (0,0)-(3,3), bench model drives error_neg -> 4 plots, 3 o_ld_y
//   pulses, each with o_err_sel=1.
//  Backpressure: hold i_plot_ready=0 for 5 cycles on 2nd pixel -> o_plot
//   held, no strobes, sequence resumes, plot count unchanged.
//  MAX_PIXELS=4, i_x_eq_x1 tied 0 -> 4 plots, then o_done=o_abort=1 for
//   1 cycle, then IDLE.
//  i_start pulsed mid-line ignored; i_reset_n=0 in STEP -> o_busy=0
//   immediately, no o_done pulse, next start draws normally.

Source files
------------

// File: rtl/lda_control_if.sv
// Signal bundle between the line-drawing sequencer and its surroundings:
// start/status, datapath strobes and flags, and the plot handshake.
interface lda_control_if;
    logic start;
    logic busy;
    logic done;
    logic abort;
    logic ld_constants;
    logic ld_x;
    logic ld_y;
    logic ld_error;
    logic err_sel;
    logic x_eq_x1;
    logic error_neg;
    logic plot;
    logic plot_ready;

    modport master (
        input  start,
        input  x_eq_x1,
        input  error_neg,
        input  plot_ready,
        output busy,
        output done,
        output abort,
        output ld_constants,
        output ld_x,
        output ld_y,
        output ld_error,
        output err_sel,
        output plot
    );

    modport slave (
        output start,
        output x_eq_x1,
        output error_neg,
        output plot_ready,
        input  busy,
        input  done,
        input  abort,
        input  ld_constants,
        input  ld_x,
        input  ld_y,
        input  ld_error,
        input  err_sel,
        input  plot
    );
endinterface

// File: rtl/lda_control.sv
// Bresenham line-drawing sequencer: load, plot, step, check per pixel.
// Option macro LDA_PIXEL_COUNT_EN exposes the accepted-plot count.
module lda_control #(
    parameter int MAX_PIXELS = 512
) (
    input  logic                            i_clk,
    input  logic                            i_reset_n,
`ifdef LDA_PIXEL_COUNT_EN
    output logic [$clog2(MAX_PIXELS+1)-1:0] o_pixel_count,
`endif
    lda_control_if.master                   bus
);

    localparam int CW = $clog2(MAX_PIXELS + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PIXELS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PLOT,
        S_STEP,
        S_CHECK,
        S_DONE,
        S_ABORT
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nx;
    logic [CW-1:0] count_inc;
    logic          accept;

    assign accept    = (state == S_PLOT) && bus.plot_ready;
    assign count_inc = count + CW'(1);

`ifdef LDA_PIXEL_COUNT_EN
    assign o_pixel_count = count;
`endif

    // State and plot-count registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= S_IDLE;
            count <= '0;
        end else begin
            state <= state_nx;
            count <= count_nx;
        end
    end

    // Plot count: cleared when a line loads, bumped on each accepted plot.
    always_comb begin
        count_nx = count;
        if (state == S_LOAD) begin
            count_nx = '0;
        end else if (accept) begin
            count_nx = count_inc;
        end
    end

    // Next state and strobes; end-of-line beats the watchdog on one accept.
    always_comb begin
        state_nx         = state;
        bus.busy         = 1'b1;
        bus.done         = 1'b0;
        bus.abort        = 1'b0;
        bus.ld_constants = 1'b0;
        bus.ld_x         = 1'b0;
        bus.ld_y         = 1'b0;
        bus.ld_error     = 1'b0;
        bus.err_sel      = 1'b0;
        bus.plot         = 1'b0;
        unique case (state)
            S_IDLE: begin
                bus.busy = 1'b0;
                if (bus.start) begin
                    state_nx = S_LOAD;
                end
            end
            S_LOAD: begin
                bus.ld_constants = 1'b1;
                state_nx         = S_PLOT;
            end
            S_PLOT: begin
                bus.plot = 1'b1;
                if (accept) begin
                    if (bus.x_eq_x1) begin
                        state_nx = S_DONE;
                    end else if (count_inc == MAX_CNT) begin
                        state_nx = S_ABORT;
                    end else begin
                        state_nx = S_STEP;
                    end
                end
            end
            S_STEP: begin
                bus.ld_x     = 1'b1;
                bus.ld_error = 1'b1;
                state_nx     = S_CHECK;
            end
            S_CHECK: begin
                if (bus.error_neg) begin
                    bus.ld_y     = 1'b1;
                    bus.ld_error = 1'b1;
                    bus.err_sel  = 1'b1;
                end
                state_nx = S_PLOT;
            end
            S_DONE: begin
                bus.done = 1'b1;
                state_nx = S_IDLE;
            end
            S_ABORT: begin
                bus.done  = 1'b1;
                bus.abort = 1'b1;
                state_nx  = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lda_control.sv
// Directed bench for lda_control: line table plus corner sequences.
// Includes a small Bresenham datapath model driving the status flags.
module tb_lda_control;

    logic i_clk = 1'b0;
    logic i_reset_n = 1'b0;

    always #5 i_clk = ~i_clk;

    lda_control_if bus ();
    lda_control_if bus2 ();

`ifdef LDA_PIXEL_COUNT_EN
    logic [9:0] pc;
    logic [2:0] pc2;
`endif

    lda_control #(.MAX_PIXELS(512)) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
`ifdef LDA_PIXEL_COUNT_EN
        .o_pixel_count (pc),
`endif
        .bus       (bus)
    );

    lda_control #(.MAX_PIXELS(4)) dut_wd (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
`ifdef LDA_PIXEL_COUNT_EN
        .o_pixel_count (pc2),
`endif
        .bus       (bus2)
    );

    int cx0 = 0;
    int cy0 = 0;
    int cx1 = 0;
    int cy1 = 0;
    int mx = 0;
    int my = 0;
    int merr = 0;

    // Datapath model (x/y step +1 only).
    always @(posedge i_clk) begin
        if (bus.ld_constants) begin
            mx   <= cx0;
            my   <= cy0;
            merr <= (cx1 - cx0) / 2;
        end else begin
            if (bus.ld_x) mx <= mx + 1;
            if (bus.ld_y) my <= my + 1;
            if (bus.ld_error)
                merr <= bus.err_sel ? merr + (cx1 - cx0) : merr - (cy1 - cy0);
        end
    end

    assign bus.x_eq_x1   = (mx == cx1);
    assign bus.error_neg = (merr < 0);
    assign bus2.x_eq_x1   = 1'b0;
    assign bus2.error_neg = 1'b0;

    int n_plot = 0;
    int n_ldx = 0;
    int n_ldy = 0;
    int n_badsel = 0;
    int n_stall_bad = 0;
    int n_done = 0;
    int n_abort = 0;
    int n_plot2 = 0;

    // Event counters sampled mid-cycle.
    always @(negedge i_clk) begin
        if (bus.plot && bus.plot_ready) n_plot <= n_plot + 1;
        if (bus.ld_x) n_ldx <= n_ldx + 1;
        if (bus.ld_y) n_ldy <= n_ldy + 1;
        if (bus.ld_y && !(bus.err_sel && bus.ld_error))
            n_badsel <= n_badsel + 1;
        if (bus.plot && !bus.plot_ready &&
            (bus.ld_x || bus.ld_y || bus.ld_error || bus.ld_constants || bus.done))
            n_stall_bad <= n_stall_bad + 1;
        if (bus.done) n_done <= n_done + 1;
        if (bus.abort) n_abort <= n_abort + 1;
        if (bus2.plot && bus2.plot_ready) n_plot2 <= n_plot2 + 1;
    end

    int n_total = 0;
    int n_pass = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Ends at cycle 1 (LOAD) of the new line.
    task automatic start_line(input int x0, input int y0,
                              input int x1, input int y1);
        cx0 = x0;
        cy0 = y0;
        cx1 = x1;
        cy1 = y1;
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Cycle index (start sampled at cycle 0) of the o_done pulse, or -1.
    task automatic wait_done(input int c0, output int lat);
        lat = -1;
        for (int c = c0; c <= c0 + 200; c++) begin
            @(negedge i_clk);
            if (bus.done) begin
                lat = c;
                break;
            end
        end
    endtask

    typedef struct {
        string name;
        int    x0;
        int    y0;
        int    x1;
        int    y1;
        int    plots;
        int    ldx;
        int    ldy;
        int    lat;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int lat;
        int p0;
        int x0s;
        int y0s;
        int sb0;
        int d0;
        int a0;
        logic ab;

        vecs[0] = '{"horiz", 0, 0, 4, 0, 5, 4, 0, 15};
        vecs[1] = '{"point", 7, 0, 7, 0, 1, 0, 0, 3};
        vecs[2] = '{"diag", 0, 0, 3, 3, 4, 3, 3, 12};
        vecs[3] = '{"shallow", 0, 0, 4, 2, 5, 4, 2, 15};

        bus.start = 1'b0;
        bus.plot_ready = 1'b1;
        bus2.start = 1'b0;
        bus2.plot_ready = 1'b1;

        #12;
        check("reset_outputs",
              int'({bus.busy, bus.done, bus.abort, bus.ld_constants,
                    bus.ld_x, bus.ld_y, bus.ld_error, bus.err_sel, bus.plot}), 0);
`ifdef LDA_PIXEL_COUNT_EN
        check("reset_count", int'(pc), 0);
`endif
        tick();
        i_reset_n = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) begin
            p0  = n_plot;
            x0s = n_ldx;
            y0s = n_ldy;
            sb0 = n_badsel;
            a0  = n_abort;
            start_line(vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1);
            wait_done(1, lat);
            ab = bus.abort;
            check({vecs[i].name, "_latency"}, lat, vecs[i].lat);
            check({vecs[i].name, "_abort"}, int'(ab), 0);
            check({vecs[i].name, "_plots"}, n_plot - p0, vecs[i].plots);
            check({vecs[i].name, "_ld_x"}, n_ldx - x0s, vecs[i].ldx);
            check({vecs[i].name, "_ld_y"}, n_ldy - y0s, vecs[i].ldy);
            check({vecs[i].name, "_err_sel"}, n_badsel - sb0, 0);
            check({vecs[i].name, "_end_y"}, my, vecs[i].y1);
            check({vecs[i].name, "_abort_cnt"}, n_abort - a0, 0);
`ifdef LDA_PIXEL_COUNT_EN
            check({vecs[i].name, "_pixel_count"}, int'(pc), vecs[i].plots);
`endif
        end

        // Backpressure on the second pixel for 5 cycles.
        p0 = n_plot;
        sb0 = n_stall_bad;
        start_line(0, 0, 2, 0);
        tick();
        tick();
        tick();
        bus.plot_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            check("bp_plot_held", int'(bus.plot), 1);
            check("bp_no_strobes",
                  int'({bus.ld_x, bus.ld_y, bus.ld_error, bus.done}), 0);
            tick();
        end
        check("bp_count_unchanged", n_plot - p0, 1);
        bus.plot_ready = 1'b1;
        wait_done(10, lat);
        check("bp_latency", lat, 14);
        check("bp_plots", n_plot - p0, 3);
        check("bp_stall_strobes", n_stall_bad - sb0, 0);

        // Start pulse mid-line is ignored, not queued.
        p0 = n_plot;
        start_line(0, 0, 2, 0);
        tick();
        tick();
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(5, lat);
        check("midstart_latency", lat, 9);
        check("midstart_plots", n_plot - p0, 3);
        tick();
        @(negedge i_clk);
        check("midstart_idle0", int'(bus.busy), 0);
        tick();
        @(negedge i_clk);
        check("midstart_idle1", int'(bus.busy), 0);

        // Watchdog instance: MAX_PIXELS=4, end never reached.
        p0 = n_plot2;
        tick();
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        lat = -1;
        ab = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge i_clk);
            if (bus2.done) begin
                lat = c;
                ab = bus2.abort;
                break;
            end
        end
        check("wd_latency", lat, 12);
        check("wd_abort", int'(ab), 1);
        check("wd_plots", n_plot2 - p0, 4);
`ifdef LDA_PIXEL_COUNT_EN
        check("wd_pixel_count", int'(pc2), 4);
`endif
        tick();
        @(negedge i_clk);
        check("wd_after", int'({bus2.busy, bus2.done, bus2.abort}), 0);

        // Reset while in STEP.
        start_line(0, 0, 4, 0);
        tick();
        tick();
        @(negedge i_clk);
        check("rst_in_step", int'(bus.ld_x), 1);
        d0 = n_done;
        #1;
        i_reset_n = 1'b0;
        #1;
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        tick();
        tick();
        i_reset_n = 1'b1;
        tick();
        check("rst_no_done", n_done - d0, 0);
        p0 = n_plot;
        start_line(0, 0, 3, 0);
        wait_done(1, lat);
        check("rst_next_latency", lat, 12);
        check("rst_next_plots", n_plot - p0, 4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
